// File: rtl/mem_master.sv
// mem_master: serialises byte/halfword/word load-store requests onto a
// word-only data memory port. Sub-word stores are done as read-modify-write.
// Faulting requests (out of range or misaligned) complete with resp_err and
// never touch memory.
module mem_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rd
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WRITE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic        err_q, err_d;
    // Holds the extracted load result, or the raw word read during RMW.
    logic [31:0] word_q, word_d;

    // Out-of-range or misaligned access for the given op.
    function automatic logic addr_fault(input logic [2:0] op, input logic [31:0] addr);
        logic f;
        f = 1'b0;
        if (addr >= 32'h0000_3000) begin
            f = 1'b1;
        end else begin
            case (op)
                OP_LW, OP_SW:        f = (addr[1:0] != 2'b00);
                OP_LH, OP_LHU, OP_SH: f = addr[0];
                default:             f = 1'b0;
            endcase
        end
        return f;
    endfunction

    // Select the addressed lane(s) of a word and extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LW:   r = word;
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of the read word with store data.
    function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [1:0] lane,
                                                input logic [31:0] word, input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        case (op)
            OP_SH: begin
                if (lane[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            OP_SB: begin
                case (lane)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    // State and latched-request registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            pc_q    <= 32'h0000_0000;
            err_q   <= 1'b0;
            word_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            word_q  <= word_d;
        end
    end

    // Next-state logic: accept in IDLE, sample memory in LOAD/RMW_RD.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        err_d   = err_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    err_d   = addr_fault(req_op, req_addr);
                    word_d  = 32'h0000_0000;
                    if (addr_fault(req_op, req_addr)) begin
                        state_d = S_RESP;
                    end else begin
                        case (req_op)
                            OP_SW:        state_d = S_WRITE;
                            OP_SH, OP_SB: state_d = S_RMW_RD;
                            default:      state_d = S_LOAD;
                        endcase
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                word_d  = load_extract(op_q, addr_q[1:0], mem_rd);
                state_d = S_RESP;
            end
            S_WRITE:  state_d = S_RESP;
            S_RMW_RD: begin
                word_d  = mem_rd;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state; memory strobes only in write states.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0000_0000;
        mem_we     = 1'b0;
        mem_wd     = 32'h0000_0000;
        mem_pc     = pc_q;
        mem_addr   = {addr_q[31:2], 2'b00};
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                mem_addr  = 32'h0000_0000;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                mem_wd = wdata_q;
            end
            S_RMW_WR: begin
                mem_we = 1'b1;
                mem_wd = store_merge(op_q, addr_q[1:0], word_q, wdata_q);
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (op_q <= OP_LBU) begin
                    resp_rdata = word_q;
                end else begin
                    resp_rdata = 32'h0000_0000;
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: a word memory model, a request-level
// reference model compared every cycle, and directed literal checks.
module tb_mem_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_pc, mem_rd;

    always #5 clk = ~clk;

    mem_master dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_pc(mem_pc),
        .mem_rd(mem_rd)
    );

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4,
                           SW = 3'd5, SH = 3'd6, SB = 3'd7;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_acc   = 0;
    int n_rv    = 0;
    int n_we    = 0;
    logic        chk_en   = 1'b0;
    logic        init_req = 1'b1;
    logic [31:0] last_wa  = 32'h0;
    logic [31:0] last_wd  = 32'h0;
    logic [31:0] pc_exp   = 32'h0;

    logic [31:0] bmem    [0:4095];
    logic [31:0] ref_mem [0:4095];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;
    exp_t q[$];

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] iv;
        iv = i;
        if (i == 4) return 32'h8899AABB;
        if (i == 8) return 32'h11223344;
        return {16'hC0DE, iv[15:0]};
    endfunction

    function automatic logic m_fault(input logic [2:0] op, input logic [31:0] a);
        if (a >= 32'h0000_3000) return 1'b1;
        if ((op == LW || op == SW) && a[1:0] != 2'b00) return 1'b1;
        if ((op == LH || op == LHU || op == SH) && a[0]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * int'(a[1:0]));
        case (op)
            LW:      return w;
            LH:      return 32'($signed(s[15:0]));
            LHU:     return {16'h0000, s[15:0]};
            LB:      return 32'($signed(s[7:0]));
            LBU:     return {24'h000000, s[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] w, input logic [31:0] d);
        logic [31:0] mask;
        int sft;
        mask = (op == SB) ? 32'h0000_00FF : (op == SH) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        sft  = 8 * int'(a[1:0]);
        return (w & ~(mask << sft)) | ((d & mask) << sft);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    assign mem_rd = bmem[mem_addr[13:2]];

    // Memory model: preload while init_req, then commit DUT writes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (init_req) begin
            for (int i = 0; i < 4096; i++) bmem[i] <= init_word(i);
        end else if (mem_we) begin
            bmem[mem_addr[13:2]] <= mem_wd;
            last_wa <= mem_addr;
            last_wd <= mem_wd;
            n_we    <= n_we + 1;
        end
    end

    // Reference model and per-cycle compare, sampled just after the falling edge.
    initial begin
        exp_t e;
        logic busy, exp_we, exp_rv;
        logic [31:0] nw;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            #1;
            busy = (q.size() != 0);
            if (chk_en) begin
                chk("req_ready", 32'(req_ready), busy ? 32'd0 : 32'd1);
                exp_we = 1'b0;
                exp_rv = 1'b0;
                if (busy) begin
                    exp_we = (q[0].op >= SW) && !q[0].err && (q[0].due - 1 == cyc);
                    exp_rv = (q[0].due == cyc);
                end
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                if (exp_we) begin
                    nw = m_store(q[0].op, q[0].addr, ref_mem[q[0].addr[13:2]], q[0].wdata);
                    chk("mem_wd", mem_wd, nw);
                    ref_mem[q[0].addr[13:2]] = nw;
                end else begin
                    chk("mem_wd_idle", mem_wd, 32'h0);
                end
                chk("mem_addr", mem_addr, busy ? {q[0].addr[31:2], 2'b00} : 32'h0);
                chk("mem_pc", mem_pc, pc_exp);
                chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
                if (resp_valid) n_rv++;
                if (exp_rv) begin
                    chk("resp_err", 32'(resp_err), 32'(q[0].err));
                    chk("resp_rdata", resp_rdata, q[0].rdata);
                    void'(q.pop_front());
                end else begin
                    chk("resp_err_idle", 32'(resp_err), 32'h0);
                    chk("resp_rdata_idle", resp_rdata, 32'h0);
                end
            end
            if (reset === 1'b0) begin
                q.delete();
                pc_exp = 32'h0;
            end else if (chk_en && req_valid && !busy) begin
                e.op    = req_op;
                e.addr  = req_addr;
                e.wdata = req_wdata;
                e.err   = m_fault(req_op, req_addr);
                e.rdata = (e.err || req_op >= SW) ? 32'h0
                          : m_load(req_op, req_addr, ref_mem[req_addr[13:2]]);
                e.due   = cyc + (e.err ? 1 : (req_op <= LBU || req_op == SW) ? 2 : 3);
                q.push_back(e);
                pc_exp = req_pc;
                n_acc++;
            end
        end
    end

    // Issue one request from a falling edge; return response data and latency.
    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] pc, output logic [31:0] rd, output logic err,
                          output int lat);
        int k;
        req_op = op; req_addr = a; req_wdata = d; req_pc = pc; req_valid = 1'b1;
        rd = 32'h0; err = 1'b0; lat = -1;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        if (!req_ready) begin
            chk("accept_wait", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 8) begin @(negedge clk); k++; end
        if (resp_valid) begin
            rd  = resp_rdata;
            err = resp_err;
            lat = k + 1;
            @(negedge clk);
        end else begin
            chk("resp_wait", 32'(resp_valid), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, we0, acc0, rv0, k;
        reset = 1'b0; req_valid = 1'b0; req_op = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; init_req = 1'b0; chk_en = 1'b1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_pc", mem_pc, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);

        // Sub-word loads from word 0x10 = 0x8899AABB.
        do_req(LB, 32'h11, 32'h0, 32'h100, rd, er, lat);
        chk("lb_11", rd, 32'hFFFFFFAA); chk("lb_lat", lat, 32'd2); chk("lb_err", 32'(er), 32'd0);
        do_req(LBU, 32'h13, 32'h0, 32'h104, rd, er, lat);
        chk("lbu_13", rd, 32'h00000088);
        do_req(LH, 32'h10, 32'h0, 32'h108, rd, er, lat);
        chk("lh_10", rd, 32'hFFFFAABB);
        do_req(LHU, 32'h12, 32'h0, 32'h10C, rd, er, lat);
        chk("lhu_12", rd, 32'h00008899);
        do_req(LW, 32'h10, 32'h0, 32'h110, rd, er, lat);
        chk("lw_10", rd, 32'h8899AABB);

        // Read-modify-write byte and halfword stores into word 0x20.
        we0 = n_we;
        do_req(SB, 32'h22, 32'hFFFFFF5A, 32'h200, rd, er, lat);
        chk("sb_lat", lat, 32'd3); chk("sb_err", 32'(er), 32'd0);
        chk("sb_we_count", n_we - we0, 32'd1);
        chk("sb_wa", last_wa, 32'h20); chk("sb_wd", last_wd, 32'h115A3344);
        do_req(SH, 32'h22, 32'h0000BEEF, 32'h204, rd, er, lat);
        do_req(LW, 32'h20, 32'h0, 32'h208, rd, er, lat);
        chk("sh_readback", rd, 32'hBEEF3344);

        // Top of the valid range and the first faulting address.
        we0 = n_we;
        do_req(SW, 32'h2FFC, 32'hDEADBEEF, 32'h300, rd, er, lat);
        chk("sw_lat", lat, 32'd2); chk("sw_wd", last_wd, 32'hDEADBEEF);
        chk("sw_we_count", n_we - we0, 32'd1);
        do_req(LW, 32'h2FFC, 32'h0, 32'h304, rd, er, lat);
        chk("lw_2ffc", rd, 32'hDEADBEEF);
        we0 = n_we;
        do_req(LW, 32'h3000, 32'h0, 32'h308, rd, er, lat);
        chk("lw_3000_err", 32'(er), 32'd1); chk("lw_3000_lat", lat, 32'd1);

        // Misaligned and out-of-range stores/loads fault without writing.
        do_req(LH, 32'h05, 32'h0, 32'h30C, rd, er, lat);
        chk("lh_05_err", 32'(er), 32'd1); chk("lh_05_rd", rd, 32'h0); chk("lh_05_lat", lat, 32'd1);
        do_req(SW, 32'h0A, 32'h12345678, 32'h310, rd, er, lat);
        chk("sw_0a_err", 32'(er), 32'd1); chk("sw_0a_lat", lat, 32'd1);
        do_req(SB, 32'h3001, 32'h0, 32'h314, rd, er, lat);
        chk("sb_3001_err", 32'(er), 32'd1);
        chk("fault_no_we", n_we - we0, 32'd0);
        chk("sw_0a_word", bmem[2], 32'hC0DE0002);

        // Reset wins over a simultaneous request.
        rv0 = n_rv;
        req_op = LW; req_addr = 32'h10; req_valid = 1'b1; reset = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1; req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_prio_no_resp", n_rv - rv0, 32'd0);

        // Reset during RMW_RD aborts the halfword store.
        we0 = n_we; rv0 = n_rv;
        req_op = SH; req_addr = 32'h40; req_wdata = 32'h1234; req_pc = 32'h400; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        @(posedge clk); @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
        chk("abort_no_we", n_we - we0, 32'd0);
        chk("abort_no_resp", n_rv - rv0, 32'd0);
        chk("abort_word", bmem[16], 32'hC0DE0010);

        // Continuous req_valid with alternating sw/lw.
        acc0 = n_acc; rv0 = n_rv;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_op    = (i % 2 == 0) ? SW : LW;
            req_addr  = 32'h200 + 32'(4 * (i / 2));
            req_wdata = 32'hA0000000 + 32'(i);
            req_pc    = 32'h500 + 32'(i);
            k = 0;
            while (!req_ready && k < 50) begin @(negedge clk); k++; end
            chk("stream_ready", 32'(req_ready), 32'd1);
            @(posedge clk); @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("stream_accepts", n_acc - acc0, 32'd6);
        chk("stream_resps", n_rv - rv0, 32'd6);
        chk("stream_word0", bmem[128], 32'hA0000000);
        chk("stream_word2", bmem[130], 32'hA0000004);
        chk("model_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
